// File: rtl/coax_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : coax_rx_buffer
//  Description : Frame receive buffer behind the coax receiver. Decoded
//                10-bit words are stored in a first-word-fall-through FIFO.
//                Frame boundaries follow the receiver's active level, and
//                receiver error codes are captured. Per-frame status (done,
//                error, overflow) is presented to the draining host logic.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock, rising edge
//    reset        in   synchronous, active-high
//    rx_active    in   receiver frame-active level
//    rx_error     in   receiver error level (rx_data holds the error code)
//    rx_data      in   receiver word / error code
//    rx_strobe    in   one-cycle pulse, rx_data holds a completed word
//    read_strobe  in   pop head word (ignored when empty)
//    data         out  head word, 0 when empty
//    empty        out  FIFO holds no words
//    full         out  FIFO holds DEPTH words
//    count        out  words held
//    receiving    out  frame in progress
//    frame_done   out  frame ended cleanly
//    error        out  frame ended in receiver error
//    error_code   out  rx_data captured on error entry
//    overflow     out  sticky: a word was dropped in the current frame
// ============================================================================
module coax_rx_buffer #(
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rx_active,
   input  logic                     rx_error,
   input  logic [9:0]               rx_data,
   input  logic                     rx_strobe,
   input  logic                     read_strobe,
   output logic [9:0]               data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     receiving,
   output logic                     frame_done,
   output logic                     error,
   output logic [9:0]               error_code,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] c_CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RECEIVING = 2'd1,
      ST_DONE      = 2'd2,
      ST_ERROR     = 2'd3
   } state_t;

   state_t          r_state;
   logic            r_receiving;
   logic            r_frame_done;
   logic            r_error;
   logic [9:0]      r_error_code;
   logic            r_overflow;
   logic            r_prev_active;
   // Set once rx_active has been seen low since reset; a receiver that is
   // already mid-frame when reset releases must not look like a frame start.
   logic            r_idle_seen;

   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic [9:0]      r_mem [DEPTH];

   logic            w_empty;
   logic            w_full;
   logic            w_start;
   logic            w_stop;
   logic            w_in_rx;
   logic            w_frame_start;
   logic            w_err_entry;
   logic            w_flush;
   logic            w_wr_en;
   logic            w_rd_en;
   logic [AW-1:0]   w_wr_addr;

   assign w_empty       = (r_count == '0);
   assign w_full        = (r_count == c_DEPTH_CNT);
   assign w_start       = rx_active & ~r_prev_active & r_idle_seen;
   assign w_stop        = ~rx_active & r_prev_active;
   assign w_in_rx       = (r_state == ST_RECEIVING);
   assign w_frame_start = w_start & ~w_in_rx;
   assign w_err_entry   = w_in_rx & rx_error;
   assign w_flush       = w_frame_start | w_err_entry;

   // A start-cycle strobe lands in entry 0 of the freshly flushed FIFO.
   assign w_wr_en   = rx_strobe & (w_frame_start | (w_in_rx & ~rx_error & ~w_full));
   assign w_wr_addr = w_frame_start ? '0 : r_wr_ptr;
   assign w_rd_en   = read_strobe & ~w_empty & ~w_flush;

   always_ff @(posedge clk) begin
      if (w_wr_en && !reset)
         r_mem[w_wr_addr] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= w_wr_en ? c_PTR_ONE : '0;
         r_count  <= w_wr_en ? c_CNT_ONE : '0;
      end else begin
         if (w_wr_en)
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_rd_en)
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_receiving   <= 1'b0;
         r_frame_done  <= 1'b0;
         r_error       <= 1'b0;
         r_error_code  <= '0;
         r_overflow    <= 1'b0;
         r_prev_active <= 1'b0;
         r_idle_seen   <= ~rx_active;
      end else begin
         r_prev_active <= rx_active;
         if (!rx_active)
            r_idle_seen <= 1'b1;
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (w_start) begin
                  r_state      <= ST_RECEIVING;
                  r_receiving  <= 1'b1;
                  r_frame_done <= 1'b0;
                  r_error      <= 1'b0;
                  r_error_code <= '0;
                  r_overflow   <= 1'b0;
               end
            end
            ST_RECEIVING: begin
               if (rx_error) begin
                  r_state      <= ST_ERROR;
                  r_receiving  <= 1'b0;
                  r_error      <= 1'b1;
                  r_error_code <= rx_data;
               end else begin
                  if (rx_strobe && w_full)
                     r_overflow <= 1'b1;
                  if (w_stop) begin
                     r_state      <= ST_DONE;
                     r_receiving  <= 1'b0;
                     r_frame_done <= 1'b1;
                  end
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_receiving  <= 1'b0;
               r_frame_done <= 1'b0;
               r_error      <= 1'b0;
            end
         endcase
      end
   end

   assign data       = w_empty ? '0 : r_mem[r_rd_ptr];
   assign empty      = w_empty;
   assign full       = w_full;
   assign count      = r_count;
   assign receiving  = r_receiving;
   assign frame_done = r_frame_done;
   assign error      = r_error;
   assign error_code = r_error_code;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: doc/coax_rx_buffer.md
# coax_rx_buffer

Frame receive buffer that sits directly downstream of the coax receiver. It takes each decoded 10-bit word from the receiver and stores it in a first-word-fall-through FIFO. It tracks frame boundaries using the receiver's `active` signal and captures receiver error codes. The host/interface logic drains the buffer and sees per-frame status: done, error, overflow.

## Interface
Parameters:
- `DEPTH`, 256: FIFO depth in 10-bit words; power of two, minimum 4. `AW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `rx_active`  in  1  receiver frame-active level.
- `rx_error`  in  1  receiver error level; high while receiver is in its error state.
- `rx_data`  in  10  receiver word. When `rx_strobe` is high it holds a data word; while `rx_error` is high it holds the error code.
- `rx_strobe`  in  1  one-cycle pulse: `rx_data` holds a completed word.
- `read_strobe`  in  1  pop the head word; ignored when `empty`.
- `data`  out  10  head word (FWFT); forced to 0 when `empty`.
- `empty`  out  1  FIFO holds no words.
- `full`  out  1  count == `DEPTH`.
- `count`  out  AW+1  words held.
- `receiving`  out  1  state == RECEIVING.
- `frame_done`  out  1  state == DONE.
- `error`  out  1  state == ERROR.
- `error_code`  out  10  `rx_data` captured on ERROR entry; holds until next frame start or reset.
- `overflow`  out  1  sticky: at least one word was dropped in the current frame.

## Operation
- `prev_active` is registered every cycle. `start = rx_active & !prev_active`. `stop = !rx_active & prev_active`.
- States:
  - IDLE.
  - RECEIVING.
  - DONE.
  - ERROR.
- Reset:
  - State goes to IDLE; pointers and `count` go to 0.
  - `error_code` = 0, `overflow` = 0, `prev_active` = 0.
  - Resulting outputs: `empty`=1, `full`=0, `data`=0, and all status outputs 0.
- IDLE / DONE / ERROR, on `start`: enter RECEIVING.
  - Same edge: flush the FIFO (pointers and count to 0), clear `overflow`, clear `error_code`.
  - Unread words from the previous frame are discarded.
- RECEIVING:
  - Priority: `rx_error` > `rx_strobe`/`stop`.
  - `rx_error`: go to ERROR, capture `error_code <= rx_data`, flush the FIFO. A same-cycle `rx_strobe` word is dropped.
  - `rx_strobe & !full`: write `rx_data` at `wr_ptr` and increment `wr_ptr`.
  - `rx_strobe & full`: drop the word and set `overflow`.
  - `stop` with no error: go to DONE. A same-cycle strobe word is still written.
- `rx_strobe` outside RECEIVING is ignored, except in the `start` cycle:
  - The flush applies first.
  - The word is then written as entry 0 (`count` becomes 1).
- `rx_error` outside RECEIVING is ignored.
- Reads:
  - `read_strobe & !empty` in IDLE, RECEIVING or DONE increments `rd_ptr`.
  - In ERROR the FIFO is empty, so reads are no-ops.
- Count and simultaneous read/write:
  - `count` changes by +1 on write only, -1 on read only, and is unchanged on simultaneous write and read.
  - When full, a write is refused even if a read happens in the same cycle; the read still pops.
  - When empty, a simultaneous read is ignored and the write is stored.
- Pointers are AW bits and wrap from `DEPTH-1` to 0. Fullness is tracked by `count`, not by pointer compare.
- Storage is an inferred memory with asynchronous read: `data = empty ? 0 : mem[rd_ptr]`.

## Timing
- `rx_strobe` at edge N:
  - `count`, `empty` and `data` reflect the word after edge N (visible in cycle N+1).
  - Write-to-`data` latency is 1 cycle.
- `read_strobe` at edge N: `data` shows the next word (or 0) in cycle N+1.
- `start` is detected in the first cycle with `rx_active`=1. `receiving` is high from the following cycle.
- `stop`, in the first cycle with `rx_active`=0: `frame_done` goes high 1 cycle later.
- `rx_error` sampled at edge N: `error`, `error_code` and `empty` are valid in cycle N+1.
- `reset` overrides every same-cycle event.
- Reset mid-frame: the buffer returns to IDLE. Receiver activity that is already in progress is not treated as a `start` until `rx_active` deasserts and reasserts.

## Test plan
- **Basic frame:** `rx_active` rises, then strobes 0x3FF, 0x001, 0x155, then `rx_active` falls.
  - `frame_done`=1 and `count`=3.
  - Three reads yield 0x3FF, 0x001, 0x155, then `empty`=1 and `data`=0.
- **Overflow (DEPTH=4):** 6 strobes in one frame.
  - `count`=4, `full`=1, `overflow`=1.
  - Reads return only the first 4 words.
  - The next `start` clears `overflow` and `count`.
- **Error:** 2 words, then `rx_error`=1 with `rx_data`=0x001 plus a same-cycle strobe.
  - `error`=1, `error_code`=0x001, `empty`=1, the strobe word is dropped, and reads are no-ops.
  - The next `start` clears everything.
- **Streaming and wrap (DEPTH=4):** 10 words, each read the cycle after it is written.
  - Output sequence matches the input sequence.
  - `count` never exceeds 1 and the pointers wrap cleanly.
  - A simultaneous read and write at `count`=1 leaves `count`=1.
- **Edge cases:**
  - Strobe in the `start` cycle after a DONE frame holding 2 unread words: `count`=1 and `data` = the new word.
  - Strobe coincident with `stop`: the word is stored and `frame_done`=1.
- **Reset mid-frame with 3 words held:**
  - All outputs return to their reset values.
  - `rx_active` still high does not start a frame until it is toggled.
